// File: rtl/cnn_pkg.sv
// cnn_pkg: shared types and constants for the CNN layer sequencers.
// Holds the sequencer state enum and the conv1 geometry constants.
package cnn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STREAM,
    DRAIN,
    DONE
  } seq_state_t;

  localparam int C1_IMG_SIZE = 32;
  localparam int C1_K        = 5;
  localparam int C1_MAPS     = 6;
  localparam int C1_OUT_DIM  = C1_IMG_SIZE - C1_K + 1;

  // Widths of an input pixel coordinate and an output-map coordinate.
  localparam int C1_POS_W = $clog2(C1_IMG_SIZE);
  localparam int C1_OUT_W = $clog2(C1_OUT_DIM);

endpackage

// File: rtl/raster_counter.sv
// raster_counter: row/col position of a raster-ordered NxN stream.
// Ports: clk, rst (async high), en (advance), row, col, last (at N-1,N-1).
module raster_counter
  import cnn_pkg::*;
#(
  parameter int N = C1_IMG_SIZE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  output logic [$clog2(N)-1:0] row,
  output logic [$clog2(N)-1:0] col,
  output logic                 last
);

  localparam int W = $clog2(N);
  localparam logic [W-1:0] MAX = W'(N - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row <= '0;
      col <= '0;
    end else if (en) begin
      if (col == MAX) begin
        col <= '0;
        row <= (row == MAX) ? '0 : row + W'(1);
      end else begin
        col <= col + W'(1);
      end
    end
  end

  assign last = (row == MAX) && (col == MAX);

endmodule

// File: rtl/conv1_sequencer.sv
// conv1_sequencer: frame controller for conv layer 1 (weights, stream, valid).
// Ports: clk, rst, start, in_valid -> in_ready, wb_read, buf_en, out_valid,
// out_last, busy, done; out_row/out_col when CONV1_SEQ_COORD_EN is defined.
module conv1_sequencer
  import cnn_pkg::*;
#(
  parameter int IMG_SIZE  = C1_IMG_SIZE,
  parameter int K         = C1_K,
  parameter int WB_CYCLES = 2,
  parameter int PIPE_LAT  = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic in_valid,
  output logic in_ready,
  output logic wb_read,
  output logic buf_en,
  output logic out_valid,
  output logic out_last,
  output logic busy,
  output logic done
`ifdef CONV1_SEQ_COORD_EN
  ,
  output logic [$clog2(IMG_SIZE-K+1)-1:0] out_row,
  output logic [$clog2(IMG_SIZE-K+1)-1:0] out_col
`endif
);

  localparam int RW = $clog2(IMG_SIZE);
  localparam int LW = $clog2(WB_CYCLES + 1);
  localparam int DW = $clog2(PIPE_LAT + 1);
  localparam logic [RW-1:0] EDGE = RW'(K - 1);

  seq_state_t state;
  logic [LW-1:0] lcnt;
  logic [DW-1:0] dcnt;
  logic [RW-1:0] row;
  logic [RW-1:0] col;
  logic last_px;
  logic tag;
  logic tag_last;
  logic [PIPE_LAT-1:0] vq;
  logic [PIPE_LAT-1:0] lq;

  assign buf_en = in_valid & in_ready;

  raster_counter #(
    .N(IMG_SIZE)
  ) u_rc (
    .clk (clk),
    .rst (rst),
    .en  (buf_en),
    .row (row),
    .col (col),
    .last(last_px)
  );

  // A beat completes a legal window once K-1 rows and cols are buffered.
  assign tag      = buf_en && (row >= EDGE) && (col >= EDGE);
  assign tag_last = buf_en && last_px;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vq <= '0;
      lq <= '0;
    end else begin
      vq[0] <= tag;
      lq[0] <= tag_last;
      for (int i = 1; i < PIPE_LAT; i++) begin
        vq[i] <= vq[i-1];
        lq[i] <= lq[i-1];
      end
    end
  end

  assign out_valid = vq[PIPE_LAT-1];
  assign out_last  = lq[PIPE_LAT-1];

`ifdef CONV1_SEQ_COORD_EN
  localparam int OW = $clog2(IMG_SIZE - K + 1);
  logic [OW-1:0] rq [PIPE_LAT];
  logic [OW-1:0] cq [PIPE_LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PIPE_LAT; i++) begin
        rq[i] <= '0;
        cq[i] <= '0;
      end
    end else begin
      rq[0] <= tag ? OW'(row - EDGE) : '0;
      cq[0] <= tag ? OW'(col - EDGE) : '0;
      for (int i = 1; i < PIPE_LAT; i++) begin
        rq[i] <= rq[i-1];
        cq[i] <= cq[i-1];
      end
    end
  end

  assign out_row = rq[PIPE_LAT-1];
  assign out_col = cq[PIPE_LAT-1];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      lcnt     <= '0;
      dcnt     <= '0;
      in_ready <= 1'b0;
      wb_read  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state   <= LOAD;
            wb_read <= 1'b1;
            busy    <= 1'b1;
            lcnt    <= LW'(1);
          end
        end
        LOAD: begin
          if (lcnt == LW'(WB_CYCLES)) begin
            state    <= STREAM;
            wb_read  <= 1'b0;
            in_ready <= 1'b1;
            lcnt     <= '0;
          end else begin
            lcnt <= lcnt + LW'(1);
          end
        end
        STREAM: begin
          if (buf_en && last_px) begin
            state    <= DRAIN;
            in_ready <= 1'b0;
            dcnt     <= DW'(1);
          end
        end
        DRAIN: begin
          if (dcnt == DW'(PIPE_LAT)) begin
            state <= DONE;
            done  <= 1'b1;
            dcnt  <= '0;
          end else begin
            dcnt <= dcnt + DW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/conv1_sequencer.md
Name: conv1_sequencer

Overview:
- Frame-level controller for the first convolutional layer (5x5 kernel, 6 maps, 32x32 input).
- On `start`, pulses the weight/bias ROM `read`, then accepts a raster-ordered pixel stream with a valid/ready handshake.
- Gates the line-buffer shift enable and tracks row/column position.
- Emits `out_valid` exactly for the cycles where the conv datapath output is a legal 28x28 window result, then signals frame completion.

Parameters:
- IMG_SIZE, 32, input image width = height in pixels.
- K, 5, kernel size; output dimension = IMG_SIZE-K+1.
- WB_CYCLES, 2, cycles `wb_read` is held high to load weights/bias (>=1).
- PIPE_LAT, 1, cycles from accepted pixel to valid datapath result (>=1).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin one frame; sampled only in IDLE.
- in_valid  in  1  upstream pixel present on the datapath `in` bus.
- in_ready  out  1  sequencer accepts a pixel this cycle.
- wb_read  out  1  drives the weights_bias `read` input.
- buf_en  out  1  drives the matrix_buffer shift enable; high = accept beat.
- out_valid  out  1  conv layer `out` holds a valid 6-map result this cycle.
- out_last  out  1  with out_valid on the final (784th by default) result.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at frame end.

Behaviour:
- Reset (async assert, sync release): state IDLE; row/col/load counters 0; valid delay line cleared; all outputs 0.
- States:
  - IDLE: start=1 -> LOAD.
  - LOAD: wb_read=1 for exactly WB_CYCLES cycles, then -> STREAM.
  - STREAM: in_ready=1; on the last pixel accepted -> DRAIN.
  - DRAIN: in_ready=0 for PIPE_LAT cycles -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- Outputs are registered except `buf_en`, which is combinational:
  - in_ready is 1 only in STREAM.
  - buf_en = in_valid & in_ready.
  - No pixel is shifted outside STREAM.
- Counters:
  - col increments per accepted beat, wraps IMG_SIZE-1 -> 0; row increments on col wrap.
  - Both hold on cycles with in_valid=0 (bubbles are legal, no data loss).
- Window-valid tag: accepted beat with row>=K-1 and col>=K-1.
  - The tag enters a PIPE_LAT-deep shift register; out_valid = its tail.
  - The register advances every cycle and inserts 0 on non-accepted cycles.
- out_last: accepted beat with row=col=IMG_SIZE-1, carried through the same delay line.
- Counts per frame:
  - Exactly (IMG_SIZE-K+1)^2 out_valid pulses; out_valid never asserts in IDLE/LOAD.
  - Exactly IMG_SIZE^2 accepted beats.
- start outside IDLE is ignored. start in the same cycle as done (DONE state) is ignored; the next frame requires start in IDLE.
- rst mid-frame aborts immediately: no done pulse, delay line flushed, counters 0.
- Widths: row/col are $clog2(IMG_SIZE) bits; load counter is $clog2(WB_CYCLES+1) bits.
- Line-buffer prefill rows produce no out_valid.

Optional Feature:
- Macro CONV1_SEQ_COORD_EN.
- Defined: adds outputs `out_row` and `out_col`, each $clog2(IMG_SIZE-K+1) bits. They give the output-map coordinate of the current out_valid result, row-major from (0,0), delayed in step with out_valid, and are 0 when out_valid=0.
- Undefined: these ports and their delay registers do not exist; all other behaviour is identical.

Decomposition:
- Shared package cnn_pkg holds:
  - state enum (IDLE, LOAD, STREAM, DRAIN, DONE);
  - C1_IMG_SIZE=32, C1_K=5, C1_MAPS=6, C1_OUT_DIM=28;
  - a clog2-width helper constant.
- One natural sub-module: raster_counter (row/col counters with enable, wrap, and a last-pixel flag), reusable by later pooling/conv layers.

Test Plan:
- Reset then start, in_valid held 1 for 1024 cycles:
  - wb_read high exactly 2 cycles.
  - in_ready high exactly 1024 cycles.
  - 784 out_valid pulses; the first arrives PIPE_LAT cycles after beat index 132 (row 4, col 4).
  - out_last coincides with the 784th pulse; done pulses PIPE_LAT+1 cycles after the final beat.
- in_valid toggled 1/0 every cycle: still 1024 buf_en beats and 784 out_valid, with no out_valid on bubble-aligned cycles.
- start asserted during STREAM and again during DONE: no state change, no second LOAD.
- rst asserted after 500 accepted beats: all outputs 0 asynchronously; no done pulse; a new start then yields a full correct frame of 784 results.
- Two back-to-back frames (start in IDLE right after done): two wb_read bursts, 1568 total out_valid, two done pulses.
- With CONV1_SEQ_COORD_EN: the first result has (out_row,out_col)=(0,0) and the last has (27,27); every row increments after col 27.
